// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the ALU serial transmitter.
//   FRAME_BITS       : length of one serial frame (start, type, 8 payload, stop)
//   TYPE_DATA/CTL    : value of the type bit for data and control frames
//   CTL_ERR/ECHO_A/B : status codes with bit 7 set (control-frame-only packets)
//   ser_state_e      : frame transmitter states
package mtm_alu_pkg;

    localparam int         FRAME_BITS = 11;
    localparam logic       TYPE_DATA  = 1'b0;
    localparam logic       TYPE_CTL   = 1'b1;
    localparam logic [7:0] CTL_ERR    = 8'h93;
    localparam logic [7:0] ECHO_A     = 8'hA5;
    localparam logic [7:0] ECHO_B     = 8'hC9;

    typedef enum logic [2:0] {IDLE, START, TYPE, DATA, STOP} ser_state_e;

endpackage

// File: rtl/mtm_alu_frame_tx.sv
// Sends one 11-bit frame: start(0), type, 8 payload bits MSB first, stop(1).
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   i_go      : load i_type/i_byte and start a frame (honoured in IDLE or STOP)
//   i_type    : frame type bit
//   i_byte    : payload byte
//   o_done    : high during the stop-bit cycle; a new i_go here chains frames
//   o_sout    : serial line, registered, idle high
module mtm_alu_frame_tx
    import mtm_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_go,
    input  logic       i_type,
    input  logic [7:0] i_byte,
    output logic       o_done,
    output logic       o_sout
);

    // r_state names the bit currently on the line.
    ser_state_e r_state, w_state_nxt;
    logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
    logic       r_sout, w_sout_nxt;
    logic       r_type;
    logic [7:0] r_byte;
    logic       w_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_bit_cnt <= 3'd0;
            r_sout    <= 1'b1;
            r_type    <= 1'b0;
            r_byte    <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_sout    <= w_sout_nxt;
            if (w_load) begin
                r_type <= i_type;
                r_byte <= i_byte;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_sout_nxt    = r_sout;
        w_load        = 1'b0;
        case (r_state)
            IDLE, STOP: begin
                // Going straight from STOP to START keeps frames back to back.
                if (i_go) begin
                    w_state_nxt = START;
                    w_sout_nxt  = 1'b0;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                    w_sout_nxt  = 1'b1;
                end
            end
            START: begin
                w_state_nxt = TYPE;
                w_sout_nxt  = r_type;
            end
            TYPE: begin
                w_state_nxt   = DATA;
                w_bit_cnt_nxt = 3'd7;
                w_sout_nxt    = r_byte[7];
            end
            DATA: begin
                if (r_bit_cnt == 3'd0) begin
                    w_state_nxt = STOP;
                    w_sout_nxt  = 1'b1;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt - 3'd1;
                    w_sout_nxt    = r_byte[r_bit_cnt - 3'd1];
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_sout_nxt  = 1'b1;
            end
        endcase
    end

    assign o_done = (r_state == STOP);
    assign o_sout = r_sout;

endmodule

// File: rtl/mtm_alu_serializer.sv
// Output-side serial transmitter for the ALU. Latches result C and status CTL
// on res_valid and sends them as 11-bit frames: DATA_BYTES data frames (C MSB
// byte first) followed by one control frame, or only the control frame when
// CTL[7] is set (error/echo).
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   C         : result word (8*DATA_BYTES bits)
//   CTL       : status byte
//   res_valid : one-cycle strobe, ignored while busy
//   busy      : registered, high from the first start bit through the last stop bit
//   sout      : serial line, idle high
module mtm_alu_serializer
    import mtm_alu_pkg::*;
#(
    parameter int DATA_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*DATA_BYTES-1:0] C,
    input  logic [7:0]              CTL,
    input  logic                    res_valid,
    output logic                    busy,
    output logic                    sout
);

    localparam int CW  = 8 * DATA_BYTES;
    localparam int BCW = $clog2(DATA_BYTES + 1);

    logic           r_busy;
    logic [CW-1:0]  r_shreg;
    logic [7:0]     r_ctl;
    logic [BCW-1:0] r_byte_cnt;   // frames still to send after the current one

    logic           w_accept, w_done, w_more, w_go, w_type;
    logic [7:0]     w_byte;

    assign w_accept = res_valid & ~r_busy;
    assign w_more   = (r_byte_cnt != '0);
    assign w_go     = w_accept | (w_done & w_more);

    // The first frame's byte comes straight from the inputs because the
    // latches are loaded on the same edge the frame starts.
    always_comb begin
        w_type = TYPE_CTL;
        w_byte = r_ctl;
        if (w_accept) begin
            if (CTL[7]) begin
                w_type = TYPE_CTL;
                w_byte = CTL;
            end else begin
                w_type = TYPE_DATA;
                w_byte = C[CW-1 -: 8];
            end
        end else if (r_byte_cnt > BCW'(1)) begin
            w_type = TYPE_DATA;
            w_byte = r_shreg[CW-1 -: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= 1'b0;
            r_shreg    <= '0;
            r_ctl      <= 8'd0;
            r_byte_cnt <= '0;
        end else if (w_accept) begin
            r_busy     <= 1'b1;
            r_ctl      <= CTL;
            r_shreg    <= C << 8;
            r_byte_cnt <= CTL[7] ? '0 : BCW'(DATA_BYTES);
        end else if (w_done) begin
            if (w_more) begin
                r_byte_cnt <= r_byte_cnt - BCW'(1);
                if (r_byte_cnt > BCW'(1))
                    r_shreg <= r_shreg << 8;
            end else begin
                r_busy <= 1'b0;
            end
        end
    end

    mtm_alu_frame_tx u_frame_tx (
        .clk    (clk),
        .rst    (rst),
        .i_go   (w_go),
        .i_type (w_type),
        .i_byte (w_byte),
        .o_done (w_done),
        .o_sout (sout)
    );

    assign busy = r_busy;

endmodule

// File: tb/tb_mtm_alu_serializer.sv
module tb_mtm_alu_serializer;
    import mtm_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] C   = 32'd0;
    logic [7:0]  CTL = 8'd0;
    logic        res_valid = 1'b0;
    logic        busy, sout;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] c;
        logic [7:0]  ctl;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mtm_alu_serializer #(.DATA_BYTES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .C         (C),
        .CTL       (CTL),
        .res_valid (res_valid),
        .busy      (busy),
        .sout      (sout)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Call at a negedge; the strobe is taken on the following posedge.
    task automatic strobe(input logic [31:0] c, input logic [7:0] ctl, input bit acc);
        exp_t e;
        C = c; CTL = ctl; res_valid = 1'b1;
        if (acc) begin
            e.c = c; e.ctl = ctl;
            sb.push_back(e);
        end
        @(negedge clk);
        res_valid = 1'b0;
    endtask

    task automatic capture(input int n, output logic [63:0] bits, output int nbusy);
        bits = '0; nbusy = 0;
        for (int i = 0; i < n; i++) begin
            bits = {bits[62:0], sout};
            if (busy) nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", busy, 1'b0);
    endtask

    // Bench deserializer: rebuilds packets from sout and checks against the scoreboard.
    bit          m_act = 0;
    int          m_cnt = 0;
    logic        m_type;
    logic [7:0]  m_byte;
    logic [31:0] m_c = 0;
    int          m_nb = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            m_act = 0; m_cnt = 0; m_c = 0; m_nb = 0;
        end else if (!m_act) begin
            if (sout == 1'b0) begin
                m_act = 1; m_cnt = 1;
            end
        end else begin
            m_cnt++;
            if (m_cnt == 2) m_type = sout;
            else if (m_cnt <= 10) m_byte = {m_byte[6:0], sout};
            else begin
                chk("stop_bit", sout, 1'b1);
                m_act = 0;
                if (m_type == TYPE_DATA) begin
                    m_c = {m_c[23:0], m_byte};
                    m_nb++;
                end else if (sb.size() == 0) begin
                    chk("unexpected_pkt", 1, 0);
                    m_c = 0; m_nb = 0;
                end else begin
                    e = sb.pop_front();
                    chk("pkt_ctl", m_byte, e.ctl);
                    chk("pkt_nbytes", m_nb, e.ctl[7] ? 0 : 4);
                    if (!e.ctl[7]) chk("pkt_c", m_c, e.c);
                    m_c = 0; m_nb = 0;
                end
            end
        end
    end

    initial begin
        logic [63:0] bits;
        int nb, n;
        logic [7:0] ctl;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_sout", sout, 1'b1);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // 1: full result packet, exact bits
        strobe(32'h12345678, 8'h05, 1);
        capture(55, bits, nb);
        chk("t1_bits", bits, {2'b00, 8'h12, 1'b1, 2'b00, 8'h34, 1'b1, 2'b00, 8'h56, 1'b1,
                              2'b00, 8'h78, 1'b1, 2'b01, 8'h05, 1'b1});
        chk("t1_busy_cycles", nb, 55);
        chk("t1_busy_after", busy, 1'b0);
        chk("t1_sout_idle", sout, 1'b1);
        @(negedge clk);

        // 2: error packet is control frame only
        strobe(32'hCAFEF00D, CTL_ERR, 1);
        capture(FRAME_BITS, bits, nb);
        chk("t2_bits", bits, {2'b01, 8'h93, 1'b1});
        chk("t2_busy_cycles", nb, 11);
        chk("t2_busy_after", busy, 1'b0);
        @(negedge clk);

        // 3: strobe mid-packet is dropped
        strobe(32'hFFFFFFFF, 8'h05, 1);
        repeat (19) @(negedge clk);
        chk("t3_busy_mid", busy, 1'b1);
        strobe(32'h00000000, 8'h00, 0);
        wait_idle(n);
        @(negedge clk);
        strobe(32'h0BADCAFE, 8'h03, 1);
        wait_idle(n);
        @(negedge clk);

        // 4: reset during third data frame
        strobe(32'hDEADBEEF, 8'h05, 0);
        repeat (24) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t4_rst_sout", sout, 1'b1);
        chk("t4_rst_busy", busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        strobe(32'h11111111, ECHO_A, 1);
        capture(FRAME_BITS, bits, nb);
        chk("t4_bits", bits, {2'b01, 8'hA5, 1'b1});
        chk("t4_busy_cycles", nb, 11);
        chk("t4_busy_after", busy, 1'b0);

        // 5: back-to-back on the first idle cycle
        for (int k = 0; k < 3; k++) begin
            strobe($urandom, 8'h05, 1);
            wait_idle(n);
            chk("t5_len", n, 55);
            chk("t5_gap_sout", sout, 1'b1);
        end

        // 6: random packets, about 10% error/echo
        for (int k = 0; k < 1000; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0: ctl = CTL_ERR;
                    1: ctl = ECHO_A;
                    2: ctl = ECHO_B;
                    default: ctl = 8'h80 | 8'($urandom);
                endcase
            end else begin
                ctl = 8'($urandom) & 8'h7F;
            end
            strobe($urandom, ctl, 1);
            wait_idle(n);
            if (k % 100 == 0) chk("t6_len", n, ctl[7] ? 11 : 55);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
